// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared types, size codes and helpers for the memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [1:0]  SZ_B      = 2'd0;
    localparam logic [1:0]  SZ_H      = 2'd1;
    localparam logic [1:0]  SZ_W      = 2'd2;

    localparam logic [31:0] c_IO_BASE = 32'h0003_0000;
    localparam logic [31:0] c_IO_MASK = 32'h0003_0000;

    // Field order must match the concatenation built in the top module.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] data;
    } ls_req_t;

    function automatic logic [2:0] byte_count(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] a, input logic [31:0] base);
        return (a & c_IO_MASK) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_if
// Description : Instruction-cache and load/store client bus of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;
    logic        ic_asking_in;
    logic [31:0] ic_addr_in;
    logic [31:0] ic_instruction_out;
    logic        ic_ready_out;
    logic        ls_asking_in;
    logic        ls_wr_in;
    logic [1:0]  ls_size_in;
    logic        ls_signed_in;
    logic [31:0] ls_addr_in;
    logic [31:0] ls_data_in;
    logic [31:0] ls_data_out;
    logic        ls_ready_out;

    modport master (
        output ic_asking_in, ic_addr_in,
        output ls_asking_in, ls_wr_in, ls_size_in, ls_signed_in, ls_addr_in, ls_data_in,
        input  ic_instruction_out, ic_ready_out, ls_data_out, ls_ready_out
    );

    modport slave (
        input  ic_asking_in, ic_addr_in,
        input  ls_asking_in, ls_wr_in, ls_size_in, ls_signed_in, ls_addr_in, ls_data_in,
        output ic_instruction_out, ic_ready_out, ls_data_out, ls_ready_out
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : req_latch
// Description : One-deep pending-request slot; latest pulse overwrites.
// Revision    : 1.0 - initial release
// ============================================================================
module req_latch #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_pause,
    input  wire logic         i_clear,
    input  wire logic         i_set,
    input  wire logic [W-1:0] i_data,
    input  wire logic         i_grant,
    output logic              o_valid,
    output logic [W-1:0]      o_data
);
    logic         r_valid;
    logic [W-1:0] r_data;

    // A pulse coinciding with a grant is a new request and must survive it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (!i_pause) begin
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_set) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else if (i_grant) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Arbitrates IC and LSB onto a byte-wide synchronous RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = c_IO_BASE
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              pause,
    input  wire logic              clear_in,
    input  wire logic              io_buffer_full,
    input  wire logic [7:0]        mem_din,
    output logic [7:0]             mem_dout,
    output logic [ADDR_W-1:0]      mem_a,
    output logic                   mem_wr,
    mem_ctrl_if.slave              bus
);
    localparam int c_LS_W = $bits(ls_req_t);

    logic              w_ic_valid;
    logic [31:0]       w_ic_addr;
    logic              w_ls_valid;
    ls_req_t           w_ls_req;
    logic [c_LS_W-1:0] w_ls_in;
    logic [c_LS_W-1:0] w_ls_out;

    state_t            r_state;
    logic [2:0]        r_k;
    logic [2:0]        r_n;
    logic              r_client_ls;
    logic              r_last_lsb;
    logic              r_sgn;
    logic              r_io;
    logic [31:0]       r_wr_data;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_mem_a;
    logic [7:0]        r_mem_dout;
    logic [31:0]       r_ic_out;
    logic [31:0]       r_ls_out;
    logic              r_paused;
    logic [7:0]        r_din_shadow;

    logic              w_idle_go;
    logic              w_gnt_ic;
    logic              w_gnt_ls;
    logic              w_last;
    logic              w_ic_done;
    logic              w_ls_rd_done;
    logic              w_st_done;
    logic              w_io_block;
    logic [7:0]        w_din;
    logic [4:0]        w_cap_sel;
    logic [4:0]        w_wr_sel;
    logic [31:0]       w_raw;
    logic [31:0]       w_ls_res;

    assign w_ls_in  = {bus.ls_wr_in, bus.ls_size_in, bus.ls_signed_in, bus.ls_addr_in, bus.ls_data_in};
    assign w_ls_req = ls_req_t'(w_ls_out);

    req_latch #(.W(32)) u_ic_slot (
        .clk     (clk),
        .rst     (rst),
        .i_pause (pause),
        .i_clear (clear_in),
        .i_set   (bus.ic_asking_in),
        .i_data  (bus.ic_addr_in),
        .i_grant (w_gnt_ic),
        .o_valid (w_ic_valid),
        .o_data  (w_ic_addr)
    );

    req_latch #(.W(c_LS_W)) u_ls_slot (
        .clk     (clk),
        .rst     (rst),
        .i_pause (pause),
        .i_clear (clear_in),
        .i_set   (bus.ls_asking_in),
        .i_data  (w_ls_in),
        .i_grant (w_gnt_ls),
        .o_valid (w_ls_valid),
        .o_data  (w_ls_out)
    );

    assign w_idle_go = (r_state == ST_IDLE) && !clear_in && !pause;
    assign w_gnt_ic  = w_idle_go && w_ic_valid && (!w_ls_valid || r_last_lsb);
    assign w_gnt_ls  = w_idle_go && w_ls_valid && !w_gnt_ic;

    // The RAM keeps reading while paused, so the byte due at the pause edge is parked.
    assign w_din     = r_paused ? r_din_shadow : mem_din;

    assign w_last       = (r_state == ST_READ) && (r_k == r_n);
    assign w_ic_done    = w_last && !r_client_ls && !pause && !clear_in;
    assign w_ls_rd_done = w_last &&  r_client_ls && !pause && !clear_in;
    assign w_st_done    = (r_state == ST_WRITE) && (r_k == r_n) && !pause;
    assign w_io_block   = r_io && io_buffer_full;

    assign w_cap_sel = {r_k[1:0] - 2'd1, 3'b000};
    assign w_wr_sel  = {r_k[1:0] + 2'd1, 3'b000};

    always_comb begin
        w_raw = r_buf;
        case (r_n)
            3'd1:    w_raw[7:0]   = w_din;
            3'd2:    w_raw[15:8]  = w_din;
            default: w_raw[31:24] = w_din;
        endcase
        case (r_n)
            3'd1:    w_ls_res = {{24{r_sgn & w_raw[7]}},  w_raw[7:0]};
            3'd2:    w_ls_res = {{16{r_sgn & w_raw[15]}}, w_raw[15:0]};
            default: w_ls_res = w_raw;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paused     <= 1'b0;
            r_din_shadow <= 8'h00;
        end else begin
            r_paused <= pause;
            if (pause && !r_paused) begin
                r_din_shadow <= mem_din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= 3'd0;
            r_n         <= 3'd0;
            r_client_ls <= 1'b0;
            r_last_lsb  <= 1'b1;
            r_sgn       <= 1'b0;
            r_io        <= 1'b0;
            r_wr_data   <= 32'h0;
            r_buf       <= 32'h0;
            r_mem_a     <= '0;
            r_mem_dout  <= 8'h00;
            r_ic_out    <= 32'h0;
            r_ls_out    <= 32'h0;
        end else if (!pause) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_ic) begin
                        r_state     <= ST_READ;
                        r_client_ls <= 1'b0;
                        r_last_lsb  <= 1'b0;
                        r_n         <= 3'd4;
                        r_k         <= 3'd0;
                        r_sgn       <= 1'b0;
                        r_buf       <= 32'h0;
                        r_mem_a     <= w_ic_addr[ADDR_W-1:0];
                    end else if (w_gnt_ls) begin
                        r_state     <= w_ls_req.wr ? ST_WRITE : ST_READ;
                        r_client_ls <= 1'b1;
                        r_last_lsb  <= 1'b1;
                        r_n         <= byte_count(w_ls_req.size);
                        r_k         <= 3'd0;
                        r_sgn       <= w_ls_req.sgn;
                        r_io        <= is_io(w_ls_req.addr, IO_BASE);
                        r_buf       <= 32'h0;
                        r_wr_data   <= w_ls_req.data;
                        r_mem_a     <= w_ls_req.addr[ADDR_W-1:0];
                        if (w_ls_req.wr) begin
                            r_mem_dout <= w_ls_req.data[7:0];
                        end
                    end
                end
                ST_READ: begin
                    if (clear_in) begin
                        r_state <= ST_IDLE;
                    end else if (r_k == r_n) begin
                        r_state <= ST_IDLE;
                        if (r_client_ls) begin
                            r_ls_out <= w_ls_res;
                        end else begin
                            r_ic_out <= w_raw;
                        end
                    end else begin
                        r_k <= r_k + 3'd1;
                        if (r_k != 3'd0) begin
                            r_buf[w_cap_sel +: 8] <= w_din;
                        end
                        if ((r_k + 3'd1) < r_n) begin
                            r_mem_a <= r_mem_a + ADDR_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    // Stores run to completion even across clear_in.
                    if (r_k == r_n) begin
                        r_state <= ST_IDLE;
                    end else if (!w_io_block) begin
                        r_k <= r_k + 3'd1;
                        if ((r_k + 3'd1) < r_n) begin
                            r_mem_a    <= r_mem_a + ADDR_W'(1);
                            r_mem_dout <= r_wr_data[w_wr_sel +: 8];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign mem_wr   = (r_state == ST_WRITE) && (r_k != r_n) && !pause && !w_io_block;

    assign bus.ic_ready_out       = w_ic_done;
    assign bus.ic_instruction_out = w_ic_done ? w_raw : r_ic_out;
    assign bus.ls_ready_out       = w_ls_rd_done || w_st_done;
    assign bus.ls_data_out        = w_ls_rd_done ? w_ls_res : r_ls_out;
endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a byte RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              pause;
    logic              clear_in;
    logic              io_buffer_full;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    mem_ctrl_if ifc();

    mem_ctrl #(.ADDR_W(ADDR_W), .IO_BASE(32'h0003_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .pause          (pause),
        .clear_in       (clear_in),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .bus            (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:262143];
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    int                ic_cnt, ls_cnt, ic_cyc, ls_cyc, wr_cnt;
    logic [31:0]       ic_word, ls_word;
    logic [ADDR_W-1:0] a_log  [0:31];
    logic              wr_log [0:31];
    int                wr_cyc [0:7];
    logic [31:0]       wr_addr[0:7];
    logic [7:0]        wr_data[0:7];

    task automatic apply_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Cycle 0 begins one posedge after the call; outputs are sampled at each negedge.
    task automatic run(input int ncyc, input int ic_at, input logic [31:0] ic_a,
                       input int ls_at, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] la, input logic [31:0] ld, input int clr_at,
                       input int p_from, input int p_len, input int io_from, input int io_len);
        ic_cnt = 0; ls_cnt = 0; ic_cyc = -1; ls_cyc = -1; wr_cnt = 0;
        ic_word = 32'h0; ls_word = 32'h0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            ifc.ic_asking_in = (c == ic_at);
            ifc.ic_addr_in   = ic_a;
            ifc.ls_asking_in = (c == ls_at);
            ifc.ls_wr_in     = wr;
            ifc.ls_size_in   = sz;
            ifc.ls_signed_in = sg;
            ifc.ls_addr_in   = la;
            ifc.ls_data_in   = ld;
            clear_in         = (c == clr_at);
            pause            = (c >= p_from) && (c < p_from + p_len);
            io_buffer_full   = (c >= io_from) && (c < io_from + io_len);
            @(negedge clk);
            if (c < 32) begin
                a_log[c]  = mem_a;
                wr_log[c] = mem_wr;
            end
            if (ifc.ic_ready_out) begin ic_cnt++; ic_cyc = c; ic_word = ifc.ic_instruction_out; end
            if (ifc.ls_ready_out) begin ls_cnt++; ls_cyc = c; ls_word = ifc.ls_data_out; end
            if (mem_wr) begin
                if (wr_cnt < 8) begin
                    wr_cyc[wr_cnt]  = c;
                    wr_addr[wr_cnt] = mem_a;
                    wr_data[wr_cnt] = mem_dout;
                end
                wr_cnt++;
            end
        end
        @(posedge clk); #1;
        ifc.ic_asking_in = 1'b0; ifc.ls_asking_in = 1'b0;
        clear_in = 1'b0; pause = 1'b0; io_buffer_full = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        n_checks++; if (mem_a !== '0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        n_checks++; if (ifc.ic_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ic_ready: got %b want 0", ifc.ic_ready_out); end
        n_checks++; if (ifc.ls_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ls_ready: got %b want 0", ifc.ls_ready_out); end
        n_checks++; if (ifc.ic_instruction_out !== 32'h0) begin n_fail++; $display("FAIL reset_ic_word: got %h want 0", ifc.ic_instruction_out); end
        n_checks++; if (ifc.ls_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_ls_data: got %h want 0", ifc.ls_data_out); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_ic_read();
        run(12, 0, 32'h100, -1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, -1, -1, 0, -1, 0);
        for (int c = 2; c <= 5; c++) begin
            n_checks++;
            if (a_log[c] !== 32'h100 + 32'(c - 2)) begin
                n_fail++; $display("FAIL ic_mem_a[%0d]: got %h want %h", c, a_log[c], 32'h100 + 32'(c - 2));
            end
        end
        n_checks++; if (ic_cnt !== 1) begin n_fail++; $display("FAIL ic_ready_count: got %0d want 1", ic_cnt); end
        n_checks++; if (ic_cyc !== 6) begin n_fail++; $display("FAIL ic_latency: got %0d want 6", ic_cyc); end
        n_checks++; if (ic_word !== 32'h0000_0513) begin n_fail++; $display("FAIL ic_word: got %h want 00000513", ic_word); end
        n_checks++; if (wr_cnt !== 0) begin n_fail++; $display("FAIL ic_no_write: got %0d want 0", wr_cnt); end
        n_checks++; if (ifc.ic_instruction_out !== 32'h0000_0513) begin n_fail++; $display("FAIL ic_word_hold: got %h want 00000513", ifc.ic_instruction_out); end
    endtask

    task automatic test_ls_load();
        run(8, -1, 32'h0, 0, 1'b0, 2'd0, 1'b1, 32'h200, 32'h0, -1, -1, 0, -1, 0);
        n_checks++; if (ls_cnt !== 1) begin n_fail++; $display("FAIL lb_ready_count: got %0d want 1", ls_cnt); end
        n_checks++; if (ls_cyc !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d want 3", ls_cyc); end
        n_checks++; if (ls_word !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_signed: got %h want ffffff80", ls_word); end
        for (int c = 2; c < 8; c++) begin
            n_checks++;
            if (a_log[c] !== 32'h200) begin n_fail++; $display("FAIL lb_single_addr[%0d]: got %h want 00000200", c, a_log[c]); end
        end
        run(8, -1, 32'h0, 0, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0, -1, -1, 0, -1, 0);
        n_checks++; if (ls_word !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_unsigned: got %h want 00000080", ls_word); end
    endtask

    task automatic test_arbitration();
        apply_reset();
        run(20, 0, 32'h100, 0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, -1, -1, 0, -1, 0);
        n_checks++; if (ic_cyc !== 6) begin n_fail++; $display("FAIL tie1_ic_cycle: got %0d want 6", ic_cyc); end
        n_checks++; if (ls_cyc !== 12) begin n_fail++; $display("FAIL tie1_ls_cycle: got %0d want 12", ls_cyc); end
        n_checks++; if (ls_word !== 32'h1234_5678) begin n_fail++; $display("FAIL tie1_ls_word: got %h want 12345678", ls_word); end
        run(20, 0, 32'h100, 0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, -1, -1, 0, -1, 0);
        n_checks++; if (ic_cyc !== 6) begin n_fail++; $display("FAIL tie2_ic_cycle: got %0d want 6", ic_cyc); end
        n_checks++; if (ls_cyc !== 12) begin n_fail++; $display("FAIL tie2_ls_cycle: got %0d want 12", ls_cyc); end
        run(10, 0, 32'h100, -1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, -1, -1, 0, -1, 0);
        run(20, 0, 32'h100, 0, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, -1, -1, 0, -1, 0);
        n_checks++; if (ls_cyc !== 6) begin n_fail++; $display("FAIL tie3_ls_cycle: got %0d want 6", ls_cyc); end
        n_checks++; if (ic_cyc !== 12) begin n_fail++; $display("FAIL tie3_ic_cycle: got %0d want 12", ic_cyc); end
        n_checks++; if (ic_word !== 32'h0000_0513) begin n_fail++; $display("FAIL tie3_ic_word: got %h want 00000513", ic_word); end
    endtask

    task automatic test_io_store();
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        run(12, -1, 32'h0, 0, 1'b1, 2'd2, 1'b0, 32'h3_0000, 32'hDEAD_BEEF, -1, -1, 0, 2, 3);
        for (int c = 2; c <= 4; c++) begin
            n_checks++;
            if (wr_log[c] !== 1'b0) begin n_fail++; $display("FAIL io_blocked_wr[%0d]: got %b want 0", c, wr_log[c]); end
        end
        n_checks++; if (wr_cnt !== 4) begin n_fail++; $display("FAIL io_write_count: got %0d want 4", wr_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_cyc[i] !== 5 + i || wr_addr[i] !== 32'h3_0000 + 32'(i) || wr_data[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL io_write[%0d]: got cyc %0d a %h d %h want cyc %0d a %h d %h",
                         i, wr_cyc[i], wr_addr[i], wr_data[i], 5 + i, 32'h3_0000 + 32'(i), exp_b[i]);
            end
        end
        n_checks++; if (ls_cnt !== 1 || ls_cyc !== 9) begin n_fail++; $display("FAIL io_store_ready: got cnt %0d cyc %0d want cnt 1 cyc 9", ls_cnt, ls_cyc); end
        n_checks++; if (ram[18'h3_0003] !== 8'hDE) begin n_fail++; $display("FAIL io_ram_top: got %h want de", ram[18'h3_0003]); end
    endtask

    task automatic test_clear();
        run(14, 0, 32'h100, 4, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 4, -1, 0, -1, 0);
        n_checks++; if (ic_cnt !== 0) begin n_fail++; $display("FAIL clr_ic_ready: got %0d want 0", ic_cnt); end
        n_checks++; if (ls_cnt !== 0) begin n_fail++; $display("FAIL clr_dropped_pulse: got %0d want 0", ls_cnt); end
        n_checks++; if (a_log[5] !== 32'h102 || a_log[8] !== 32'h102) begin n_fail++; $display("FAIL clr_idle_addr: got %h %h want 00000102", a_log[5], a_log[8]); end
        run(8, -1, 32'h0, 0, 1'b1, 2'd1, 1'b0, 32'h300, 32'h0000_A5C3, 3, -1, 0, -1, 0);
        n_checks++; if (ls_cnt !== 1 || ls_cyc !== 4) begin n_fail++; $display("FAIL clr_store_ready: got cnt %0d cyc %0d want cnt 1 cyc 4", ls_cnt, ls_cyc); end
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL clr_store_count: got %0d want 2", wr_cnt); end
        n_checks++; if (ram[18'h300] !== 8'hC3 || ram[18'h301] !== 8'hA5) begin n_fail++; $display("FAIL clr_store_ram: got %h %h want c3 a5", ram[18'h300], ram[18'h301]); end
    endtask

    task automatic test_pause();
        run(12, -1, 32'h0, 0, 1'b0, 2'd1, 1'b1, 32'h400, 32'h0, -1, 3, 4, -1, 0);
        for (int c = 3; c <= 6; c++) begin
            n_checks++;
            if (a_log[c] !== 32'h401 || wr_log[c] !== 1'b0) begin
                n_fail++; $display("FAIL pause_frozen[%0d]: got a %h wr %b want a 00000401 wr 0", c, a_log[c], wr_log[c]);
            end
        end
        n_checks++; if (ls_cnt !== 1 || ls_cyc !== 8) begin n_fail++; $display("FAIL pause_ready: got cnt %0d cyc %0d want cnt 1 cyc 8", ls_cnt, ls_cyc); end
        n_checks++; if (ls_word !== 32'hFFFF_9AFE) begin n_fail++; $display("FAIL pause_half: got %h want ffff9afe", ls_word); end
    endtask

    initial begin
        rst = 1'b1; pause = 1'b0; clear_in = 1'b0; io_buffer_full = 1'b0;
        ifc.ic_asking_in = 1'b0; ifc.ic_addr_in = 32'h0;
        ifc.ls_asking_in = 1'b0; ifc.ls_wr_in = 1'b0; ifc.ls_size_in = 2'd0;
        ifc.ls_signed_in = 1'b0; ifc.ls_addr_in = 32'h0; ifc.ls_data_in = 32'h0;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h100] = 8'h13; ram[18'h101] = 8'h05; ram[18'h102] = 8'h00; ram[18'h103] = 8'h00;
        ram[18'h104] = 8'h78; ram[18'h105] = 8'h56; ram[18'h106] = 8'h34; ram[18'h107] = 8'h12;
        ram[18'h200] = 8'h80;
        ram[18'h400] = 8'hFE; ram[18'h401] = 8'h9A;

        test_reset();
        test_ic_read();
        test_ls_load();
        test_arbitration();
        test_io_store();
        test_clear();
        test_pause();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Sits directly upstream of the instruction cache; it is the memory side that serves cache misses.
- Also serves the load/store unit.
- Arbitrates both clients onto one byte-wide synchronous RAM port, sequences multi-byte transfers, and returns assembled 32-bit instructions or load data with a one-cycle ready pulse.

Parameters:
- ADDR_W, 32, width of the RAM address bus.
- IO_BASE, 32'h0003_0000, I/O region base; addresses with addr[17:16]==2'b11 are I/O.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pause  in  1  global stall; all state frozen while high
- clear_in  in  1  synchronous pipeline flush
- io_buffer_full  in  1  UART buffer full; blocks I/O writes
- mem_din  in  8  RAM read data; valid the cycle after the address is presented
- mem_dout  out  8  RAM write data
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  RAM write enable
- ic_asking_in  in  1  IC fetch request; one-cycle pulse
- ic_addr_in  in  32  IC fetch address
- ic_instruction_out  out  32  fetched word
- ic_ready_out  out  1  one-cycle pulse; word valid
- ls_asking_in  in  1  LSB request; one-cycle pulse
- ls_wr_in  in  1  1 = store, 0 = load
- ls_size_in  in  2  0 = byte, 1 = half, 2 = word
- ls_signed_in  in  1  sign-extend load result
- ls_addr_in  in  32  LSB address
- ls_data_in  in  32  store data
- ls_data_out  out  32  load result
- ls_ready_out  out  1  one-cycle pulse; load data valid or store complete

Behaviour:
- Reset (async, rst=1):
  - All outputs 0.
  - State IDLE; both pending slots empty.
  - last_grant = LSB, so IC wins the first tie.
- Request capture:
  - An asking pulse latches its address/attributes into that client's pending slot.
  - A new pulse while the slot is pending overwrites the slot (latest wins).
  - Capture happens regardless of state.
- States: IDLE, READ, WRITE.
- IDLE transitions:
  - With pending slots, grant one client.
  - If both are pending, grant the one not in last_grant (round-robin).
  - IC grant -> READ with N=4.
  - LSB load -> READ with N = 1/2/4 from size.
  - LSB store -> WRITE with N = 1/2/4.
  - The granted slot clears on grant.
- READ:
  - mem_a = addr+k in busy cycle k (k=0..N-1).
  - Byte k is captured from mem_din in busy cycle k+1 into bits [8k+7:8k].
  - After the byte N-1 capture, the requester's ready is high for exactly one cycle, then -> IDLE.
  - Word-read latency: the request pulse's edge latches the slot; grant next edge; ready high in the 6th cycle after the pulse cycle.
- Load result:
  - Unsigned: zero-extend.
  - Signed: replicate bit 8N-1.
  - ic_instruction_out is always a full little-endian word.
- WRITE:
  - Busy cycle k drives mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - ls_ready_out pulses the cycle after byte N-1 is written.
- I/O writes:
  - While the address is in the I/O region and io_buffer_full=1, hold mem_wr=0 and do not advance k.
  - Resume when io_buffer_full drops.
- mem_wr is 0 in every IDLE/READ cycle; mem_a/mem_dout hold their last value when idle.
- clear_in=1 (synchronous):
  - Empties both pending slots.
  - An in-flight IC read or LSB load aborts to IDLE with no ready pulse.
  - An in-flight store completes and pulses ls_ready_out.
  - Same-cycle asking pulses are dropped.
- pause=1:
  - All registers hold; mem_wr and both ready outputs are forced 0.
  - A ready pulse due during pause is emitted on the first unpaused cycle.
- Address arithmetic wraps modulo 2^ADDR_W; no alignment check.
- rst mid-transfer: the transfer is discarded immediately; no ready pulse.

Decomposition:
- Package mem_ctrl_pkg:
  - State encoding (IDLE/READ/WRITE).
  - Size codes (SZ_B=0, SZ_H=1, SZ_W=2).
  - IO_BASE / I/O region mask.
  - Byte-count function size -> N.
- Sub-module req_latch:
  - Pending slot: valid bit, address, attributes, set on pulse, clear on grant or clear_in.
  - Instantiated twice (IC, LSB).

Test Plan:
- IC pulse, addr=0x100, RAM bytes 13 05 00 00 -> mem_a 0x100..0x103; ic_instruction_out=0x00000513; ic_ready_out one cycle, 6 cycles after the pulse.
- LSB signed byte load from 0x200 holding 0x80 -> ls_data_out=0xFFFFFF80; unsigned load -> 0x00000080; a single RAM address is issued.
- IC and LSB pulse in the same cycle after reset -> IC served first, LSB next; the following tie goes to the IC again only if the LSB was granted last.
- LSB word store 0xDEADBEEF to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then writes EF, BE, AD, DE; ls_ready_out pulses once.
- clear_in during busy cycle 2 of an IC read -> no ic_ready_out, state IDLE; clear_in during a store -> the store finishes with ls_ready_out.
- pause asserted for 4 cycles mid-half-load -> outputs frozen, mem_wr=0; the result matches the unpaused value 4 cycles later.
